switch_allocator: RTL and testbench

Per-output round-robin switch allocator sitting directly downstream of the router's input block: consumes each input port's switch request and computed output port, grants at most one input per output per cycle subject to downstream on/off flow control, and drives the crossbar select. Grants return to the input ports as the pop/forward strobe. Wormhole packet locking holds an output to one input from head to tail flit.

---
 rtl/noc_params.sv | 30 +++
 rtl/switch_allocator_rr_arbiter.sv | 36 +++
 rtl/switch_allocator.sv | 129 ++++++++++++
 tb/tb_switch_allocator.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
`default_nettype none
// ---------------------------------------------------------------------------
// noc_params : shared router port type, direction indices and lock states.
// Revision   : 1.0
// ---------------------------------------------------------------------------
package noc_params;

  localparam int PORT_NUM = 5;
  localparam int PORT_W   = $clog2(PORT_NUM);

  typedef logic [PORT_W-1:0] port_t;

  localparam port_t LOCAL = port_t'(0);
  localparam port_t NORTH = port_t'(1);
  localparam port_t SOUTH = port_t'(2);
  localparam port_t EAST  = port_t'(3);
  localparam port_t WEST  = port_t'(4);

  typedef enum logic [0:0] {
    LOCK_IDLE   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_t;

  // Round-robin successor of p among n ports.
  function automatic port_t port_inc(input port_t p, input int n);
    return (int'(p) >= n - 1) ? '0 : p + port_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_allocator_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick of the first request at or
//              after ptr_i, wrapping; one-hot grant plus encoded index.
// Revision   : 1.0
// ---------------------------------------------------------------------------
module rr_arbiter
  import noc_params::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0] req_i,
  input  port_t        ptr_i,
  output logic [N-1:0] gnt_o,
  output port_t        idx_o,
  output logic         valid_o
);

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      int c;
      c = int'(ptr_i) + i;
      if (c >= N) c = c - N;
      if (!valid_o && req_i[port_t'(c)]) begin
        valid_o              = 1'b1;
        gnt_o[port_t'(c)]    = 1'b1;
        idx_o                = port_t'(c);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// switch_allocator : per-output round-robin switch allocation with optional
//                    wormhole packet locking (macro SA_PACKET_LOCK_EN).
// Revision         : 1.0
// ---------------------------------------------------------------------------
module switch_allocator
  import noc_params::*;
#(
  parameter int PORT_NUM = noc_params::PORT_NUM
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic  [PORT_NUM-1:0] switch_request_i,
  input  port_t [PORT_NUM-1:0] out_port_i,
  input  logic  [PORT_NUM-1:0] is_head_i,
  input  logic  [PORT_NUM-1:0] is_tail_i,
  input  logic  [PORT_NUM-1:0] on_off_i,
  output logic  [PORT_NUM-1:0] valid_sel_o,
  output port_t [PORT_NUM-1:0] xb_sel_o,
  output logic  [PORT_NUM-1:0] xb_valid_o
);

  logic [PORT_NUM-1:0][PORT_NUM-1:0] gnt_mat;

`ifndef SA_PACKET_LOCK_EN
  logic unused_flit_type;
  assign unused_flit_type = ^{is_head_i, is_tail_i};
`endif

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    localparam port_t OUT_ID = port_t'(o);

    logic [PORT_NUM-1:0] req_vec, elig_vec, arb_gnt, gnt;
    port_t               arb_idx, gnt_idx, rr_q, rr_d, xb_q, xb_d;
    logic                arb_valid, gnt_valid;

    always_comb begin
      req_vec = '0;
      for (int p = 0; p < PORT_NUM; p++)
        req_vec[p] = switch_request_i[p] && (out_port_i[p] == OUT_ID);
    end

`ifdef SA_PACKET_LOCK_EN
    lock_state_t lock_q, lock_d;
    port_t       owner_q, owner_d;
    // Only head flits may open a packet on an idle output.
    assign elig_vec = (lock_q == LOCK_IDLE) ? (req_vec & is_head_i) : '0;
`else
    assign elig_vec = req_vec;
`endif

    rr_arbiter #(.N(PORT_NUM)) u_arb (
      .req_i   (elig_vec),
      .ptr_i   (rr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
    );

    always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      rr_d      = rr_q;
`ifdef SA_PACKET_LOCK_EN
      lock_d    = lock_q;
      owner_d   = owner_q;
      if (!rst && on_off_i[o]) begin
        if (lock_q == LOCK_LOCKED) begin
          if (req_vec[owner_q]) begin
            gnt_valid    = 1'b1;
            gnt_idx      = owner_q;
            gnt[owner_q] = 1'b1;
            if (is_tail_i[owner_q]) lock_d = LOCK_IDLE;
          end
        end else if (arb_valid) begin
          gnt_valid = 1'b1;
          gnt_idx   = arb_idx;
          gnt       = arb_gnt;
          rr_d      = port_inc(arb_idx, PORT_NUM);
          if (!is_tail_i[arb_idx]) begin
            lock_d  = LOCK_LOCKED;
            owner_d = arb_idx;
          end
        end
      end
`else
      if (!rst && on_off_i[o] && arb_valid) begin
        gnt_valid = 1'b1;
        gnt_idx   = arb_idx;
        gnt       = arb_gnt;
        rr_d      = port_inc(arb_idx, PORT_NUM);
      end
`endif
      xb_d = gnt_valid ? gnt_idx : xb_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rr_q    <= '0;
        xb_q    <= '0;
`ifdef SA_PACKET_LOCK_EN
        lock_q  <= LOCK_IDLE;
        owner_q <= '0;
`endif
      end else begin
        rr_q    <= rr_d;
        xb_q    <= xb_d;
`ifdef SA_PACKET_LOCK_EN
        lock_q  <= lock_d;
        owner_q <= owner_d;
`endif
      end
    end

    assign gnt_mat[o]    = gnt;
    assign xb_valid_o[o] = gnt_valid;
    assign xb_sel_o[o]   = gnt_valid ? gnt_idx : xb_q;
  end

  // Each input targets a single output, so the OR never merges two grants.
  always_comb begin
    valid_sel_o = '0;
    for (int o = 0; o < PORT_NUM; o++) valid_sel_o = valid_sel_o | gnt_mat[o];
  end

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_switch_allocator : directed scenarios plus random packet traffic
//                       checked against a behavioural allocation model.
// Revision            : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_switch_allocator;
  import noc_params::*;

  localparam int N = PORT_NUM;
`ifdef SA_PACKET_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic  [N-1:0] req, hd, tl, onoff;
  port_t [N-1:0] dst;
  logic  [N-1:0] valid_sel_o, xb_valid_o;
  port_t [N-1:0] xb_sel_o;

  switch_allocator #(.PORT_NUM(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .switch_request_i (req),
    .out_port_i       (dst),
    .is_head_i        (hd),
    .is_tail_i        (tl),
    .on_off_i         (onoff),
    .valid_sel_o      (valid_sel_o),
    .xb_sel_o         (xb_sel_o),
    .xb_valid_o       (xb_valid_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: pointer, lock flag, owner and held crossbar select.
  int rr[N], own[N], xbh[N];
  bit lk[N];
  int nrr[N], nown[N], nxbh[N];
  bit nlk[N];
  logic  [N-1:0] exp_vs, exp_xv;
  port_t [N-1:0] exp_xs;

  task automatic model_reset();
    for (int o = 0; o < N; o++) begin
      rr[o] = 0; own[o] = 0; xbh[o] = 0; lk[o] = 1'b0;
    end
  endtask

  task automatic model_eval();
    exp_vs = '0;
    exp_xv = '0;
    for (int o = 0; o < N; o++) begin
      int g;
      g = -1;
      nrr[o] = rr[o]; nlk[o] = lk[o]; nown[o] = own[o]; nxbh[o] = xbh[o];
      if (onoff[o]) begin
        if (LOCK && lk[o]) begin
          if (req[own[o]] && int'(dst[own[o]]) == o) g = own[o];
        end else begin
          for (int k = 0; k < N; k++) begin
            int p;
            p = (rr[o] + k) % N;
            if (g < 0 && req[p] && int'(dst[p]) == o && (!LOCK || hd[p])) g = p;
          end
        end
      end
      if (g >= 0) begin
        exp_vs[g] = 1'b1;
        exp_xv[o] = 1'b1;
        nxbh[o]   = g;
        if (LOCK && lk[o]) begin
          if (tl[g]) nlk[o] = 1'b0;
        end else begin
          nrr[o] = (g + 1) % N;
          if (LOCK && !tl[g]) begin nlk[o] = 1'b1; nown[o] = g; end
        end
      end
      exp_xs[o] = port_t'(nxbh[o]);
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    for (int o = 0; o < N; o++) begin
      rr[o] = nrr[o]; lk[o] = nlk[o]; own[o] = nown[o]; xbh[o] = nxbh[o];
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req = '0; hd = '0; tl = '0; onoff = '1;
    for (int p = 0; p < N; p++) dst[p] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    req = '1; hd = '1; tl = '1; onoff = '1;
    for (int p = 0; p < N; p++) dst[p] = port_t'(p);
    #1;
    n_cmp++;
    if (valid_sel_o !== '0 || xb_valid_o !== '0) begin
      n_bad++;
      $display("FAIL reset_valid vs=%b xv=%b required 0", valid_sel_o, xb_valid_o);
    end
    n_cmp++;
    if (xb_sel_o !== '0) begin
      n_bad++;
      $display("FAIL reset_xbsel got=%h required 0", xb_sel_o);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_inputs();
  endtask

  task automatic test_single_packet();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req[1] = 1'b1; dst[1] = EAST; hd[1] = (i == 0); tl[1] = (i == 2);
      #1 model_eval();
      n_cmp++;
      if (valid_sel_o !== exp_vs || xb_valid_o !== exp_xv || xb_sel_o !== exp_xs) begin
        n_bad++;
        $display("FAIL single_model flit%0d vs=%b/%b xv=%b/%b xs=%h/%h", i,
                 valid_sel_o, exp_vs, xb_valid_o, exp_xv, xb_sel_o, exp_xs);
      end
      n_cmp++;
      if (valid_sel_o[1] !== 1'b1 || xb_sel_o[EAST] !== port_t'(1)) begin
        n_bad++;
        $display("FAIL single_grant flit%0d vs1=%b xs=%0d required 1/1", i,
                 valid_sel_o[1], xb_sel_o[EAST]);
      end
      tick();
    end
    clear_inputs();
    // Pointer must now sit at 2: of inputs 0,2,3, input 2 wins.
    for (int p = 0; p < 4; p++) begin
      if (p != 1) begin req[p] = 1'b1; dst[p] = EAST; hd[p] = 1'b1; tl[p] = 1'b1; end
    end
    #1;
    n_cmp++;
    if (valid_sel_o !== 5'b00100) begin
      n_bad++;
      $display("FAIL single_rr_after got=%b required 00100", valid_sel_o);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_contention();
    int exp_seq[4] = '{0, 2, 4, 0};
    logic [N-1:0] oh;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < N; p += 2) begin
        req[p] = 1'b1; dst[p] = LOCAL; hd[p] = 1'b1; tl[p] = 1'b1;
      end
      #1 model_eval();
      oh = '0;
      oh[exp_seq[i]] = 1'b1;
      n_cmp++;
      if (valid_sel_o !== oh || xb_sel_o[LOCAL] !== port_t'(exp_seq[i])) begin
        n_bad++;
        $display("FAIL contention step%0d vs=%b xs=%0d required %b/%0d", i,
                 valid_sel_o, xb_sel_o[LOCAL], oh, exp_seq[i]);
      end
      n_cmp++;
      if (valid_sel_o !== exp_vs || xb_valid_o !== exp_xv || xb_sel_o !== exp_xs) begin
        n_bad++;
        $display("FAIL contention_model step%0d vs=%b/%b xv=%b/%b", i,
                 valid_sel_o, exp_vs, xb_valid_o, exp_xv);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_lock_hold();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      if (c <= 3) begin
        req[3] = 1'b1; dst[3] = NORTH; hd[3] = (c == 0); tl[3] = (c == 3);
      end
      if (c >= 1) begin
        req[0] = 1'b1; dst[0] = NORTH; hd[0] = 1'b1; tl[0] = 1'b0;
      end
      #1 model_eval();
      n_cmp++;
      if (valid_sel_o !== exp_vs || xb_valid_o !== exp_xv || xb_sel_o !== exp_xs) begin
        n_bad++;
        $display("FAIL lock_model cyc%0d vs=%b/%b xs=%h/%h", c,
                 valid_sel_o, exp_vs, xb_sel_o, exp_xs);
      end
`ifdef SA_PACKET_LOCK_EN
      if (c <= 4) begin
        n_cmp++;
        if (valid_sel_o !== ((c <= 3) ? 5'b01000 : 5'b00001)) begin
          n_bad++;
          $display("FAIL lock_hold cyc%0d got=%b", c, valid_sel_o);
        end
      end
`endif
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    int fi;
    fi = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      clear_inputs();
      onoff[WEST] = !(c >= 2 && c <= 5);
      if (fi < 4) begin
        req[2] = 1'b1; dst[2] = WEST; hd[2] = (fi == 0); tl[2] = (fi == 3);
      end
      if (c >= 2) begin
        req[1] = 1'b1; dst[1] = WEST; hd[1] = 1'b1; tl[1] = 1'b1;
      end
      #1 model_eval();
      n_cmp++;
      if (valid_sel_o !== exp_vs || xb_valid_o !== exp_xv || xb_sel_o !== exp_xs) begin
        n_bad++;
        $display("FAIL backp_model cyc%0d vs=%b/%b xs=%h/%h", c,
                 valid_sel_o, exp_vs, xb_sel_o, exp_xs);
      end
      if (c >= 2 && c <= 6) begin
        n_cmp++;
`ifdef SA_PACKET_LOCK_EN
        if (valid_sel_o !== ((c == 6) ? 5'b00100 : 5'b00000)) begin
`else
        if (valid_sel_o !== ((c == 6) ? 5'b00010 : 5'b00000)) begin
`endif
          n_bad++;
          $display("FAIL backpressure cyc%0d got=%b", c, valid_sel_o);
        end
      end
      if (exp_vs[2]) fi++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_parallel();
    do_reset();
    for (int p = 0; p < N; p++) begin
      req[p] = 1'b1; dst[p] = port_t'((p + 1) % N); hd[p] = 1'b1; tl[p] = 1'b1;
    end
    #1;
    n_cmp++;
    if (valid_sel_o !== '1 || xb_valid_o !== '1) begin
      n_bad++;
      $display("FAIL parallel_valid vs=%b xv=%b required all ones", valid_sel_o, xb_valid_o);
    end
    for (int o = 0; o < N; o++) begin
      n_cmp++;
      if (xb_sel_o[o] !== port_t'((o + N - 1) % N)) begin
        n_bad++;
        $display("FAIL parallel_xbsel out%0d got=%0d required %0d", o, xb_sel_o[o],
                 (o + N - 1) % N);
      end
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    req[3] = 1'b1; dst[3] = SOUTH; hd[3] = 1'b1; tl[3] = 1'b0;
    tick();
    hd[3] = 1'b0;
    #1 model_eval();
    n_cmp++;
    if (valid_sel_o !== exp_vs || xb_sel_o !== exp_xs) begin
      n_bad++;
      $display("FAIL areset_pre vs=%b/%b xs=%h/%h", valid_sel_o, exp_vs, xb_sel_o, exp_xs);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (valid_sel_o !== '0 || xb_valid_o !== '0 || xb_sel_o !== '0) begin
      n_bad++;
      $display("FAIL areset_immediate vs=%b xv=%b xs=%h required 0", valid_sel_o,
               xb_valid_o, xb_sel_o);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_inputs();
    req[1] = 1'b1; dst[1] = SOUTH; hd[1] = 1'b1; tl[1] = 1'b0;
    #1 model_eval();
    n_cmp++;
    if (valid_sel_o !== 5'b00010 || xb_sel_o[SOUTH] !== port_t'(1)) begin
      n_bad++;
      $display("FAIL areset_recover vs=%b xs=%0d required 00010/1", valid_sel_o,
               xb_sel_o[SOUTH]);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    int len[N], pos[N];
    int bad_here;
    bad_here = 0;
    do_reset();
    for (int p = 0; p < N; p++) begin len[p] = 0; pos[p] = 0; end
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++) begin
        if (len[p] == 0 && $urandom_range(0, 3) != 0) begin
          len[p] = $urandom_range(1, 4);
          pos[p] = 0;
          dst[p] = port_t'($urandom_range(0, N - 1));
        end
        req[p]   = (len[p] != 0);
        hd[p]    = (pos[p] == 0);
        tl[p]    = (pos[p] == len[p] - 1);
        onoff[p] = ($urandom_range(0, 3) != 0);
      end
      #1 model_eval();
      n_cmp++;
      if (valid_sel_o !== exp_vs || xb_valid_o !== exp_xv || xb_sel_o !== exp_xs) begin
        n_bad++;
        bad_here++;
        if (bad_here <= 10)
          $display("FAIL random cyc%0d vs=%b/%b xv=%b/%b xs=%h/%h", c, valid_sel_o,
                   exp_vs, xb_valid_o, exp_xv, xb_sel_o, exp_xs);
      end
      for (int p = 0; p < N; p++) begin
        if (exp_vs[p]) begin
          pos[p]++;
          if (pos[p] == len[p]) len[p] = 0;
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_single_packet();
    test_contention();
    test_lock_hold();
    test_backpressure();
    test_parallel();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
